// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recoded digit
// and the operand-width legality check.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // One radix-4 digit: magnitude 0/1/2 with a separate sign.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } digit_t;

    function automatic bit width_ok(input int w);
        return (w >= 4) && (w % 2 == 0);
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: multiplier triplet {b[2i+1], b[2i], b[2i-1]} to a
// signed digit in {-2,-1,0,+1,+2}.
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output digit_t     digit
);

    always_comb begin
        digit     = '0;
        digit.one = triplet[1] ^ triplet[0];
        digit.two = (triplet == 3'b011) || (triplet == 3'b100);
        // 111 is a zero digit, so it must not carry a negative sign.
        digit.neg = triplet[2] & ~(triplet[1] & triplet[0]);
    end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: one digit per clock, signed or unsigned
// operands selected per operation, ready/valid on both sides.
module booth_r4_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);

    localparam int STEPS = WIDTH / 2 + 1;
    localparam int CW    = $clog2(STEPS + 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("booth_r4_seq_multiplier: WIDTH must be even and >= 4");
    end

    state_t                   state, state_nx;
    logic signed [WIDTH+1:0]  mcand;
    logic        [WIDTH+1:0]  mplier;
    logic                     bm1;
    logic signed [WIDTH+2:0]  acc;
    logic        [CW-1:0]     cnt;
    logic                     sgn;

    digit_t                   dig;
    logic signed [WIDTH+2:0]  mag, pp, sum, acc_nx;
    logic        [WIDTH+1:0]  mplier_nx;
    logic        [2*WIDTH-1:0] res;
    logic                     ovf_nx;
    logic                     last_step;

    booth_r4_encoder u_enc (
        .triplet ({mplier[1:0], bm1}),
        .digit   (dig)
    );

    assign last_step = (cnt == CW'(STEPS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        mag       = '0;
        if (dig.two)      mag = {mcand, 1'b0};
        else if (dig.one) mag = {mcand[WIDTH+1], mcand};
        pp        = dig.neg ? -mag : mag;
        sum       = acc + pp;
        // Arithmetic shift of {acc, B} by two: sign fills acc, acc low bits feed B.
        acc_nx    = {{2{sum[WIDTH+2]}}, sum[WIDTH+2:2]};
        mplier_nx = {sum[1:0], mplier[WIDTH+1:2]};
        res       = {acc_nx[WIDTH-3:0], mplier_nx};
        if (sgn) ovf_nx = !((&res[2*WIDTH-1:WIDTH-1]) || !(|res[2*WIDTH-1:WIDTH-1]));
        else     ovf_nx = |res[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)             state_nx = BUSY;
            BUSY:    if (last_step)            state_nx = DONE;
            DONE:    if (out_ready)            state_nx = IDLE;
            default:                           state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            bm1      <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            sgn      <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand  <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                    mplier <= is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
                    bm1    <= 1'b0;
                    acc    <= '0;
                    cnt    <= '0;
                    sgn    <= is_signed;
                end
                BUSY: begin
                    acc    <= acc_nx;
                    mplier <= mplier_nx;
                    bm1    <= mplier[1];
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        product  <= res;
                        overflow <= ovf_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Bench: directed checks on an 8-bit instance, randomized traffic with
// backpressure on a 32-bit instance against an arithmetic reference model.
module tb_booth_r4_seq_multiplier;

    localparam int NR = 1500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv8 = 0, ir8, sg8 = 0, ov8, or8 = 0, of8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;

    logic        iv32 = 0, ir32, sg32 = 0, ov32, or32 = 0, of32;
    logic [31:0] a32 = 0, b32 = 0;
    logic [63:0] p32;

    booth_r4_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(sg8), .out_valid(ov8), .out_ready(or8), .product(p8), .overflow(of8)
    );

    booth_r4_seq_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .is_signed(sg32), .out_valid(ov32), .out_ready(or32), .product(p32), .overflow(of32)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact product and fit flag from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint      sp;
        logic [63:0] up;
        logic        o;
        if (s) begin
            sp = longint'($signed(x)) * longint'($signed(y));
            o  = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
            return {o, 64'(sp)};
        end
        up = {32'b0, x} * {32'b0, y};
        return {(up >= 64'h1_0000_0000), up};
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!ir8 && g < 100) begin @(negedge clk); g++; end
        chk("op8_ready", {63'b0, ir8}, 64'd1);
        a8 = a; b8 = b; sg8 = s; iv8 = 1;
        @(negedge clk);
        iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = ~s;
        lat = 0;
        while (!ov8 && lat < 50) begin @(negedge clk); lat++; end
    endtask

    task automatic take8(input string tag);
        or8 = 1;
        @(negedge clk);
        or8 = 0;
        chk({tag, "_ir"}, {63'b0, ir8}, 64'd1);
        chk({tag, "_ov"}, {63'b0, ov8}, 64'd0);
    endtask

    logic [64:0] exp_q[$];

    initial begin
        int lat;
        logic [15:0] hold_p;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_ir8", {63'b0, ir8}, 64'd1);
        chk("rst_ov8", {63'b0, ov8}, 64'd0);
        chk("rst_p8",  {48'b0, p8},  64'd0);
        chk("rst_of8", {63'b0, of8}, 64'd0);
        chk("rst_ir32", {63'b0, ir32}, 64'd1);
        chk("rst_p32", p32, 64'd0);

        op8(8'hFD, 8'h05, 1, lat);
        chk("t1_lat", 64'(lat), 64'd5);
        chk("t1_p", {48'b0, p8}, 64'hFFF1);
        chk("t1_of", {63'b0, of8}, 64'd0);
        take8("t1");

        op8(8'h80, 8'h80, 1, lat);
        chk("t2s_p", {48'b0, p8}, 64'h4000);
        chk("t2s_of", {63'b0, of8}, 64'd1);
        take8("t2s");
        op8(8'hFF, 8'hFF, 0, lat);
        chk("t2u_p", {48'b0, p8}, 64'hFE01);
        chk("t2u_of", {63'b0, of8}, 64'd1);
        take8("t2u");

        op8(8'h80, 8'h02, 0, lat);
        chk("t3u_p", {48'b0, p8}, 64'h0100);
        chk("t3u_of", {63'b0, of8}, 64'd1);
        take8("t3u");
        // -256 needs more than 8 signed bits, so the fit flag is set.
        op8(8'h80, 8'h02, 1, lat);
        chk("t3s_p", {48'b0, p8}, 64'hFF00);
        chk("t3s_of", {63'b0, of8}, 64'd1);
        take8("t3s");

        op8(8'h00, 8'hB7, 1, lat);
        chk("zero_p", {48'b0, p8}, 64'h0);
        chk("zero_of", {63'b0, of8}, 64'd0);
        take8("zero");

        op8(8'h07, 8'h09, 0, lat);
        hold_p = p8;
        chk("t4_p", {48'b0, hold_p}, 64'd63);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_p",  {48'b0, p8}, 64'd63);
            chk("t4_hold_ov", {63'b0, ov8}, 64'd1);
            chk("t4_hold_ir", {63'b0, ir8}, 64'd0);
        end
        take8("t4");

        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; sg8 = 0; iv8 = 1;
        @(negedge clk);
        iv8 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t5_ir", {63'b0, ir8}, 64'd1);
        chk("t5_ov", {63'b0, ov8}, 64'd0);
        chk("t5_p",  {48'b0, p8},  64'd0);
        repeat (8) @(negedge clk);
        chk("t5_noout", {63'b0, ov8}, 64'd0);
        op8(8'd7, 8'd6, 1, lat);
        chk("t5_p2", {48'b0, p8}, 64'd42);
        chk("t5_lat2", 64'(lat), 64'd5);
        take8("t5");

        fork
            begin : producer
                for (int i = 0; i < NR; i++) begin
                    logic [31:0] ra, rb;
                    logic        rs;
                    int          g;
                    ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
                    case (i)
                        0: begin ra = 32'h8000_0000; rb = 32'h8000_0000; rs = 1; end
                        1: begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; rs = 0; end
                        2: begin ra = 32'h0;         rb = 32'h1234_5678; rs = 1; end
                        3: begin ra = 32'hFFFF_FFFF; rb = 32'h0;         rs = 0; end
                        4: begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; rs = 1; end
                        default: ;
                    endcase
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a32 = ra; b32 = rb; sg32 = rs; iv32 = 1;
                    g = 0;
                    while (!ir32 && g < 200) begin @(negedge clk); g++; end
                    if (!ir32) begin
                        chk("rnd_in_timeout", 64'd0, 64'd1);
                        iv32 = 0;
                        break;
                    end
                    exp_q.push_back(model(ra, rb, rs));
                    @(negedge clk);
                    iv32 = 0; a32 = $urandom; b32 = $urandom; sg32 = ~rs;
                end
            end
            begin : consumer
                int          got;
                int          cyc;
                logic [64:0] e;
                got = 0; cyc = 0;
                while (got < NR && cyc < NR * 60) begin
                    @(negedge clk);
                    cyc++;
                    or32 = ($urandom_range(0, 3) != 0);
                    if (ov32 && or32) begin
                        if (exp_q.size() == 0) chk("rnd_dup", 64'd1, 64'd0);
                        else begin
                            e = exp_q.pop_front();
                            chk("rnd_prod", p32, e[63:0]);
                            chk("rnd_ovf", {63'b0, of32}, {63'b0, e[64]});
                        end
                        got++;
                    end
                end
                @(negedge clk);
                or32 = 0;
                chk("rnd_count", 64'(got), 64'(NR));
                chk("rnd_left", 64'(exp_q.size()), 64'd0);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
